// File: rtl/adder_pkg.sv
// Shared types and helpers for the pipelined adder: segment adder selection and segment sizing.
package adder_pkg;

    typedef enum logic {
        ARCH_RCA,
        ARCH_CLA
    } arch_e;

    function automatic int unsigned seg_width(input int unsigned n, input int unsigned s);
        return n / s;
    endfunction

endpackage

// File: rtl/adder_seg.sv
// W-bit combinational segment adder; ripple-carry or parallel-prefix lookahead chosen by ARCH.
module adder_seg
    import adder_pkg::*;
#(
    parameter int unsigned W    = 8,
    parameter arch_e       ARCH = ARCH_CLA
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         c_i,
    output logic [W-1:0] s_o,
    output logic         c_o
);

    logic [W-1:0] p;
    logic [W-1:0] g;
    logic [W:0]   c;

    assign p = a_i ^ b_i;
    assign g = a_i & b_i;

    if (ARCH == ARCH_RCA) begin : g_rca
        always_comb begin
            c    = '0;
            c[0] = c_i;
            for (int unsigned i = 0; i < W; i++) begin
                c[i+1] = g[i] | (p[i] & c[i]);
            end
        end
    end else begin : g_cla
        logic [W-1:0] gp;
        logic [W-1:0] pp;

        // Kogge-Stone prefix; walking i downward keeps each level's inputs unmodified
        always_comb begin
            gp = g;
            pp = p;
            for (int unsigned d = 1; d < W; d = d * 2) begin
                for (int unsigned i = W - 1; i >= d; i--) begin
                    gp[i] = gp[i] | (pp[i] & gp[i-d]);
                    pp[i] = pp[i] & pp[i-d];
                end
            end
        end

        always_comb begin
            c    = '0;
            c[0] = c_i;
            for (int unsigned i = 0; i < W; i++) begin
                c[i+1] = gp[i] | (pp[i] & c_i);
            end
        end
    end

    assign s_o = p ^ c[W-1:0];
    assign c_o = c[W];

endmodule

// File: rtl/adder_pipe.sv
// Pipelined N-bit add/subtract: S carry segments, one per stage, with operand skew and
// result deskew so every segment of a beat leaves together. Whole-pipe stall on backpressure.
module adder_pipe
    import adder_pkg::*;
#(
    parameter int unsigned N    = 32,
    parameter int unsigned S    = 4,
    parameter string       ARCH = "CLA"
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         sub,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         ci,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] s,
    output logic         co,
    output logic         ovf
);

    localparam int unsigned W        = seg_width(N, S);
    localparam arch_e       ARCH_SEL = (ARCH == "RCA") ? ARCH_RCA : ARCH_CLA;

    if (S == 0 || S > N || (N % S) != 0) begin : g_bad_cfg
        $error("adder_pipe: N must be a multiple of S with 1 <= S <= N");
    end

    logic         advance;
    logic [N-1:0] bx;
    logic         c0;
    logic [S-1:0] vld_q;
    logic [S-1:0] vld_d;
    logic [S-1:0] carry;

    assign advance   = ~vld_q[S-1] | out_ready;
    assign in_ready  = advance;
    assign out_valid = vld_q[S-1];
    assign co        = carry[S-1];

    always_comb begin
        bx = sub ? ~b : b;
        c0 = sub | ci;
    end

    always_comb begin
        vld_d = vld_q;
        if (advance) begin
            vld_d[0] = in_valid;
            for (int unsigned i = 1; i < S; i++) begin
                vld_d[i] = vld_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_d;
        end
    end

    for (genvar k = 0; k < S; k++) begin : g_seg
        logic [W-1:0] opa;
        logic [W-1:0] opb;
        logic [W-1:0] sum;
        logic         cin;
        logic         cout;
        logic         c_q;
        logic [W-1:0] r_q [S-k];

        if (k == 0) begin : g_head
            assign opa = a[W-1:0];
            assign opb = bx[W-1:0];
            assign cin = c0;
        end else begin : g_skew
            // Segment k operands wait k cycles for the carry to reach them
            logic [W-1:0] a_sk_q [k];
            logic [W-1:0] b_sk_q [k];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int unsigned d = 0; d < k; d++) begin
                        a_sk_q[d] <= '0;
                        b_sk_q[d] <= '0;
                    end
                end else if (advance) begin
                    a_sk_q[0] <= a[k*W +: W];
                    b_sk_q[0] <= bx[k*W +: W];
                    for (int unsigned d = 1; d < k; d++) begin
                        a_sk_q[d] <= a_sk_q[d-1];
                        b_sk_q[d] <= b_sk_q[d-1];
                    end
                end
            end

            assign opa = a_sk_q[k-1];
            assign opb = b_sk_q[k-1];
            assign cin = carry[k-1];
        end

        adder_seg #(
            .W    (W),
            .ARCH (ARCH_SEL)
        ) u_seg (
            .a_i (opa),
            .b_i (opb),
            .c_i (cin),
            .s_o (sum),
            .c_o (cout)
        );

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                c_q <= 1'b0;
                for (int unsigned d = 0; d < S - k; d++) begin
                    r_q[d] <= '0;
                end
            end else if (advance) begin
                c_q    <= cout;
                r_q[0] <= sum;
                for (int unsigned d = 1; d < S - k; d++) begin
                    r_q[d] <= r_q[d-1];
                end
            end
        end

        assign carry[k]     = c_q;
        assign s[k*W +: W]  = r_q[S-k-1];

        if (k == S - 1) begin : g_flags
            logic ovf_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ovf_q <= 1'b0;
                end else if (advance) begin
                    ovf_q <= (opa[W-1] == opb[W-1]) & (sum[W-1] != opa[W-1]);
                end
            end

            assign ovf = ovf_q;
        end
    end

endmodule

// File: tb/tb_adder_pipe.sv
// Self-checking bench: four adder_pipe configurations share one randomized stimulus stream,
// each scored against an arithmetic reference model; instance 0 (N=32,S=4) also sees backpressure.
module tb_adder_pipe;

    localparam int unsigned NDUT = 4;

    typedef logic [127:0] w_t;

    logic                   clk;
    logic                   rst;
    logic                   in_valid;
    logic                   sub;
    logic [63:0]            a_drv;
    logic [63:0]            b_drv;
    logic                   ci;
    logic                   ordy0;
    logic [NDUT-1:0]        ordy;
    logic [NDUT-1:0]        rdy;
    logic [NDUT-1:0]        vld;
    logic [NDUT-1:0][15:0]  pend;
    logic                   lat_en;
    logic                   bp;
    int                     cyc;
    int unsigned            n_chk;
    int unsigned            n_pass;

    assign ordy = {{(NDUT-1){1'b1}}, ordy0};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input w_t got, input w_t exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic int unsigned cfg_n(input int unsigned g);
        case (g)
            0:       return 32;
            1:       return 8;
            2:       return 16;
            default: return 64;
        endcase
    endfunction

    function automatic int unsigned cfg_s(input int unsigned g);
        case (g)
            0:       return 4;
            1:       return 1;
            2:       return 16;
            default: return 8;
        endcase
    endfunction

    // Returns {ovf, co, s} for an n-bit add/subtract computed with wide integer arithmetic
    function automatic logic [65:0] ref_model(input int unsigned n, input logic sb,
                                              input logic [63:0] av, input logic [63:0] bv,
                                              input logic cv);
        logic [129:0]        modv, ua, ub, ur, half;
        logic signed [129:0] sa, sb_s, sr;
        logic                c, o;
        modv = 130'd1 << n;
        half = modv >> 1;
        ua   = {66'd0, av} & (modv - 130'd1);
        ub   = {66'd0, bv} & (modv - 130'd1);
        sa   = ua[n-1] ? $signed(ua - modv) : $signed(ua);
        sb_s = ub[n-1] ? $signed(ub - modv) : $signed(ub);
        if (sb) begin
            ur = ua - ub;
            c  = (ua >= ub);
            sr = sa - sb_s;
        end else begin
            ur = ua + ub + {129'd0, cv};
            c  = (ur >= modv);
            sr = sa + sb_s + $signed({129'd0, cv});
        end
        o  = (sr >= $signed(half)) || (sr < -$signed(half));
        ur = ur & (modv - 130'd1);
        return {o, c, ur[63:0]};
    endfunction

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int unsigned GN = cfg_n(g);
        localparam int unsigned GS = cfg_s(g);

        logic          in_ready_w;
        logic          out_valid_w;
        logic          co_w;
        logic          ovf_w;
        logic [GN-1:0] s_w;
        logic [65:0]   exp_q [$];
        int            cyc_q [$];

        adder_pipe #(
            .N    (GN),
            .S    (GS),
            .ARCH ((g == 1) ? "RCA" : "CLA")
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid),
            .in_ready  (in_ready_w),
            .sub       (sub),
            .a         (a_drv[GN-1:0]),
            .b         (b_drv[GN-1:0]),
            .ci        (ci),
            .out_valid (out_valid_w),
            .out_ready (ordy[g]),
            .s         (s_w),
            .co        (co_w),
            .ovf       (ovf_w)
        );

        assign rdy[g]  = in_ready_w;
        assign vld[g]  = out_valid_w;
        assign pend[g] = 16'(exp_q.size());

        always @(negedge clk) begin
            logic [63:0] s64;
            s64         = '0;
            s64[GN-1:0] = s_w;
            if (rst) begin
                exp_q.delete();
                cyc_q.delete();
                check($sformatf("g%0d rst_valid", g), w_t'(out_valid_w), w_t'(0));
                check($sformatf("g%0d rst_data", g), w_t'({ovf_w, co_w, s64}), w_t'(0));
            end else begin
                check($sformatf("g%0d in_ready", g), w_t'(in_ready_w),
                      w_t'(!out_valid_w || ordy[g]));
                if (out_valid_w) begin
                    if (exp_q.size() == 0) begin
                        check($sformatf("g%0d spurious", g), w_t'(out_valid_w), w_t'(0));
                    end else begin
                        check($sformatf("g%0d result", g), w_t'({ovf_w, co_w, s64}),
                              w_t'(exp_q[0]));
                        if (ordy[g]) begin
                            if (lat_en) check($sformatf("g%0d latency", g),
                                              w_t'(cyc - cyc_q[0]), w_t'(GS));
                            void'(exp_q.pop_front());
                            void'(cyc_q.pop_front());
                        end
                    end
                end
                if (in_valid && in_ready_w) begin
                    exp_q.push_back(ref_model(GN, sub, a_drv, b_drv, ci));
                    cyc_q.push_back(cyc);
                end
            end
        end
    end

    task automatic send(input logic sb, input logic [63:0] av, input logic [63:0] bv,
                        input logic cv);
        logic took;
        took     = 1'b0;
        in_valid = 1'b1;
        sub      = sb;
        a_drv    = av;
        b_drv    = bv;
        ci       = cv;
        for (int t = 0; t < 200 && !took; t++) begin
            @(negedge clk);
            took = rdy[0];
            @(posedge clk);
            #1;
            if (bp) ordy0 = 1'($urandom_range(0, 1));
        end
        in_valid = 1'b0;
        check("send_accept", w_t'(took), w_t'(1));
    endtask

    // Leaves the bench at the negedge where instance 0 first shows out_valid
    task automatic wait_out(output int lat, output logic seen);
        lat  = 1;
        seen = 1'b0;
        for (int t = 0; t < 40 && !seen; t++) begin
            @(negedge clk);
            if (vld[0]) seen = 1'b1;
            else begin
                @(posedge clk);
                #1;
                lat++;
            end
        end
    endtask

    function automatic logic [63:0] rnd64();
        logic [63:0] v;
        v = {$urandom, $urandom};
        case ($urandom_range(0, 7))
            0:       v = '1;
            1:       v = '0;
            2:       v = 64'h7F7F_7F7F_7FFF_FFFF;
            3:       v = 64'h8080_8080_8000_0000;
            default: ;
        endcase
        return v;
    endfunction

    task automatic directed(input string tag, input logic sb, input logic [63:0] av,
                            input logic [63:0] bv, input logic cv, input logic [33:0] exp);
        int   lat;
        logic seen;
        send(sb, av, bv, cv);
        wait_out(lat, seen);
        check({tag, " seen"}, w_t'(seen), w_t'(1));
        check({tag, " lat"}, w_t'(lat), w_t'(4));
        check({tag, " s"}, w_t'(g_dut[0].s_w), w_t'(exp[31:0]));
        check({tag, " co"}, w_t'(g_dut[0].co_w), w_t'(exp[32]));
        check({tag, " ovf"}, w_t'(g_dut[0].ovf_w), w_t'(exp[33]));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc      = 0;
        n_chk    = 0;
        n_pass   = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        sub      = 1'b0;
        a_drv    = '0;
        b_drv    = '0;
        ci       = 1'b0;
        ordy0    = 1'b1;
        lat_en   = 1'b1;
        bp       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        directed("carry_ripple", 1'b0, '1, 64'd1, 1'b0, {1'b0, 1'b1, 32'h0000_0000});
        directed("add_ovf", 1'b0, 64'h7FFF_FFFF, 64'd1, 1'b0, {1'b1, 1'b0, 32'h8000_0000});
        directed("sub_ovf", 1'b1, 64'h8000_0000, 64'd1, 1'b0, {1'b1, 1'b1, 32'h7FFF_FFFF});
        directed("sub_ci_ignored", 1'b1, 64'd5, 64'd7, 1'b1, {1'b0, 1'b0, 32'hFFFF_FFFE});

        for (int i = 0; i < 512; i++) begin
            send(1'($urandom_range(0, 1)), rnd64(), rnd64(), 1'($urandom_range(0, 1)));
        end
        repeat (20) @(posedge clk);
        #1;

        send(1'b0, 64'h1111_2222_3333_4444, 64'h0101_0202_0303_0404, 1'b1);
        send(1'b1, 64'h0F0F_0F0F_0F0F_0F0F, 64'h00FF_00FF_00FF_00FF, 1'b0);
        send(1'b0, 64'hDEAD_BEEF_CAFE_F00D, 64'h1234_5678_9ABC_DEF0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst main valid", w_t'(vld[0]), w_t'(0));
        check("async_rst main s", w_t'(g_dut[0].s_w), w_t'(0));
        check("async_rst s1 valid", w_t'(vld[1]), w_t'(0));
        check("async_rst s1 s", w_t'(g_dut[1].s_w), w_t'(0));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        directed("after_rst", 1'b0, 64'd100, 64'd23, 1'b1, {1'b0, 1'b0, 32'd124});

        lat_en = 1'b0;
        bp     = 1'b1;
        for (int i = 0; i < 300; i++) begin
            send(1'($urandom_range(0, 1)), rnd64(), rnd64(), 1'($urandom_range(0, 1)));
        end
        bp    = 1'b0;
        ordy0 = 1'b1;
        repeat (24) @(posedge clk);
        #1;
        lat_en = 1'b1;
        for (int g = 0; g < NDUT; g++) begin
            check($sformatf("g%0d drained", g), w_t'(pend[g]), w_t'(0));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/adder_pipe.md
Name: adder_pipe

Overview:
- Parametrised, pipelined successor to the combinational ripple-carry and carry-lookahead adders.
- Splits an N-bit add/subtract into S carry-chain segments, one segment per pipeline stage, with operand skew and result deskew registers.
- Valid/ready handshake on input and output, whole-pipe stall on backpressure, carry-out and signed-overflow flags.
- Used wherever a full-width combinational carry chain misses timing.

Parameters:
- N, 32, operand/result width; must be a multiple of S
- S, 4, number of pipeline stages = carry segments; 1 <= S <= N; segment width W = N/S
- ARCH, "CLA", segment adder type: "RCA" or "CLA"

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  pipe accepts a beat this cycle
- sub  input  1  0: s = a + b + ci; 1: s = a - b (ci ignored)
- a  input  N  operand A
- b  input  N  operand B
- ci  input  1  carry-in, add mode only
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts a result
- s  output  N  sum/difference, modulo 2^N
- co  output  1  carry-out of bit N-1; in sub mode, 1 = no borrow (a >= b unsigned)
- ovf  output  1  two's-complement signed overflow

Behaviour:
- Reset (async assert, sync release): all stage valid bits 0 and all data registers 0, so out_valid=0, s=0, co=0, ovf=0. in_ready=1 after reset.
- Operand preparation at accept:
  - bx = sub ? ~b : b
  - c0 = sub ? 1 : ci
- Stage k (0..S-1) adds segment k, bits [k*W +: W], of a and bx with the carry registered by stage k-1; stage 0 uses c0.
- Segment k operands are delayed k cycles (skew); segment k result is delayed S-1-k cycles (deskew), so all segments of one beat emerge together.
- Latency: exactly S cycles from accept (in_valid & in_ready) to out_valid when out_ready stays 1. Throughput: 1 beat/cycle.
- Stall: advance = ~out_valid | out_ready.
  - in_ready = advance.
  - When advance=0, every pipeline register (data and valid) holds.
  - No per-stage bubble collapsing.
- Bubbles: a cycle with in_valid=0 and advance=1 inserts valid=0 into stage 0. Data registers may load don't-care values but need not toggle.
- out_valid=1 with out_ready=0: s, co, ovf are held stable until the handshake completes.
- co is the carry-out of the top segment, registered with the result.
- ovf = (a[N-1] == bx[N-1]) & (s[N-1] != a[N-1]). The operand sign bits are carried to the last stage alongside segment S-1.
- S=1: single registered adder, latency 1.
- Wrap-around: modulo 2^N, no saturation.
- Reset mid-operation discards all in-flight beats; none may appear after reset release.
- in_valid is sampled only when in_ready=1; no combinational path from in_valid to in_ready.

Decomposition:
- Shared package adder_pkg:
  - arch_e enum {ARCH_RCA, ARCH_CLA}
  - function seg_width(N,S)
  - elaboration assertion that N % S == 0
- Natural sub-module: adder_seg, a W-bit combinational adder selecting the existing adder_rca or adder_cla by ARCH (generate). adder_pipe instantiates S of them plus skew/deskew shift registers.

Test Plan:
1. N=32, S=4: a=32'hFFFF_FFFF, b=1, ci=0, sub=0, out_ready=1 -> 4 cycles later s=0, co=1, ovf=0; carry must ripple through all 4 stages.
2. Signed overflow: a=32'h7FFF_FFFF, b=1, add -> s=32'h8000_0000, ovf=1, co=0. Sub: a=32'h8000_0000, b=1 -> s=32'h7FFF_FFFF, ovf=1, co=1.
3. Back-to-back: 512 random beats with in_valid=1 continuously, each checked against a+b+ci or a-b from a reference model. Results appear in order, one per cycle, first at cycle 4.
4. Backpressure: out_ready toggled randomly (50%) while streaming -> no beat lost or duplicated, s stable while out_valid & ~out_ready, in_ready == ~out_valid | out_ready.
5. Reset mid-stream: assert rst with 3 beats in flight -> out_valid=0, s=0 immediately (asynchronous). After release, the first out_valid occurs only S cycles after a new accept.
6. Parameter sweep: (N,S,ARCH) = (8,1,RCA), (16,16,CLA), (64,8,CLA); run scenarios 1 and 3 -> latency == S, results match the reference model.
